mseq_code_sched: RTL

MSEQ_CODE_SCHED -- requirements
Module: mseq_code_sched

---
 rtl/mseq_code_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mseq_code_sched.sv
// mseq_code_sched: round-robin scheduler that hands the shared M-sequence
// generator to one requester at a time. It latches that requester's shift
// code, waits for the generator's frame boundary, then forwards one
// registered frame of chips.
//
// Output handshake: chip_out is meaningful only in cycles where chip_valid=1.
// There is no back-pressure, so each valid chip is taken in the cycle it is
// shown. chip_last marks the final valid chip. gnt is one-hot, or zero in IDLE.
module mseq_code_sched #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 63,
  parameter int CHIP_LAT  = 1,
  parameter int TMO       = 126
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] req_code,
  output logic [NREQ-1:0]   gnt,
  output logic              chip_out,
  output logic              chip_valid,
  output logic              chip_last,
  output logic              busy,
  output logic              err,
  output logic [5:0]        gen_code,
  input  logic              gen_ready,
  input  logic              gen_out
);

  localparam int RW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (FRAME_LEN > TMO) ? FRAME_LEN : TMO;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] FL_C       = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_LAST_C  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] TMO_C      = CW'(TMO);
  localparam logic [CW-1:0] TMO_LAST_C = CW'(TMO - 1);
  localparam logic [CW-1:0] LAT_LAST_C = CW'((CHIP_LAT > 0) ? CHIP_LAT - 1 : 0);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_LAT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [5:0]        gen_code_q, gen_code_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              chip_out_q, chip_out_d;
  logic              chip_valid_q, chip_valid_d;
  logic              chip_last_q, chip_last_d;

  logic              found;
  logic [RW-1:0]     win_idx;
  logic [RW-1:0]     arb_sel;
  logic [5:0]        code_sel;

  // Round-robin search starting at rr_q; picks the first asserted request.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    arb_sel  = '0;
    code_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_sel = RW'((int'(rr_q) + k) % NREQ);
      if (!found && req[arb_sel]) begin
        found   = 1'b1;
        win_idx = arb_sel;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (RW'(k) == win_idx) code_sel = req_code[6*k +: 6];
    end
  end

  // Next-state and next-output logic. One counter serves all timed states:
  // ARM timeout, LAT delay and RUN chip count. It restarts at 0 on every state entry.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gen_code_d   = gen_code_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    chip_out_d   = 1'b0;
    chip_valid_d = 1'b0;
    chip_last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = NREQ'(1) << win_idx;
          gen_code_d = code_sel;
          rr_d       = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + RW'(1);
          cnt_d      = '0;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (gen_ready) begin
          cnt_d   = '0;
          state_d = (CHIP_LAT > 0) ? S_LAT : S_RUN;
        end else if (cnt_q >= TMO_LAST_C) begin
          // Generator never reached a frame boundary: give up without chips.
          err_d   = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != TMO_C) begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_LAT: begin
        if (cnt_q == LAT_LAST_C) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_RUN: begin
        if (cnt_q == FL_C) begin
          // The last chip is on the outputs now; drop the grant and return to IDLE.
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          chip_out_d   = gen_out;
          chip_valid_d = 1'b1;
          chip_last_d  = (cnt_q == FL_LAST_C);
          cnt_d        = cnt_q + ONE_C;
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      gen_code_q   <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
      chip_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gen_code_q   <= gen_code_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      chip_out_q   <= chip_out_d;
      chip_valid_q <= chip_valid_d;
      chip_last_q  <= chip_last_d;
    end
  end

  assign gnt        = gnt_q;
  assign gen_code   = gen_code_q;
  assign err        = err_q;
  assign chip_out   = chip_out_q;
  assign chip_valid = chip_valid_q;
  assign chip_last  = chip_last_q;
  assign busy       = (state_q != S_IDLE);

endmodule
